// File: rtl/inverse_calculator_pkg.sv
// Shared definitions for the inverse calculator: opcode encoding, FSM state
// encoding and the default operand width.
package inverse_calc_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] OP_DIV  = 2'd0;
  localparam logic [1:0] OP_REM  = 2'd1;
  localparam logic [1:0] OP_LOG2 = 2'd2;
  localparam logic [1:0] OP_RSVD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/inverse_calculator_div_step.sv
// One combinational restoring-division step.
//   rem_in       : partial remainder (always < divisor in normal use)
//   dividend_bit : next dividend bit shifted into the remainder LSB
//   divisor      : divisor magnitude
//   rem_out      : next partial remainder
//   q_bit        : quotient bit produced by this step
module div_step
  import inverse_calc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] trial;

  // One extra bit keeps the shifted remainder exact; bit WIDTH of the
  // difference is the borrow, i.e. the trial subtraction went negative.
  assign trial   = {rem_in, dividend_bit} - {1'b0, divisor};
  assign q_bit   = ~trial[WIDTH];
  assign rem_out = q_bit ? trial[WIDTH-1:0] : {rem_in[WIDTH-2:0], dividend_bit};

endmodule

// File: rtl/inverse_calculator.sv
// Multi-cycle signed divide / remainder / floor-log2 unit.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, accepted only while ready
//   sel        : 0=DIV 1=REM 2=LOG2 3=reserved
//   x, y       : signed operands (y unused for LOG2)
//   ready      : idle, a request can be accepted
//   done       : one-cycle pulse when out/err are updated
//   out, err   : result and error flag, held until the next completion
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; operands latched on acceptance
// ST_RUN  | WIDTH iterations: restoring div step or leading-zero shift
// ST_FIX  | sign fixup and error rules, register out/err, pulse done
module inverse_calculator
  import inverse_calc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};

  state_t state_q, state_d;

  logic [CW-1:0]    iter_cnt;
  logic [CW-1:0]    lz_cnt;
  logic [1:0]       op_q;
  logic             sx_q, sy_q, x_min_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  // Dividend shifts out of the top while quotient bits enter the bottom;
  // for LOG2 the same register is the leading-one search shifter.
  logic [WIDTH-1:0] shreg_q;

  logic [WIDTH-1:0] x_mag, y_mag;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic             last_iter;
  logic [WIDTH-1:0] res_d;
  logic             err_d;

  // |MIN| wraps to MIN, which is the correct unsigned magnitude.
  assign x_mag = x[WIDTH-1] ? (ZERO - x) : x;
  assign y_mag = y[WIDTH-1] ? (ZERO - y) : y;

  assign last_iter = (iter_cnt == CW'(WIDTH - 1));
  assign ready     = (state_q == ST_IDLE);

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in       (rem_q),
    .dividend_bit (shreg_q[WIDTH-1]),
    .divisor      (dvs_q),
    .rem_out      (step_rem),
    .q_bit        (step_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start)     state_d = ST_RUN;
      ST_RUN:  if (last_iter) state_d = ST_FIX;
      ST_FIX:                 state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Sign fixup and error rules, evaluated from the final datapath state.
  always_comb begin
    res_d = ZERO;
    err_d = 1'b0;
    case (op_q)
      OP_DIV: begin
        if (dvs_q == ZERO) begin
          err_d = 1'b1;
        end else if (x_min_q && sy_q && dvs_q == WIDTH'(1)) begin
          res_d = MIN_VAL;
          err_d = 1'b1;
        end else begin
          res_d = (sx_q ^ sy_q) ? (ZERO - shreg_q) : shreg_q;
        end
      end
      OP_REM: begin
        if (dvs_q == ZERO) err_d = 1'b1;
        else               res_d = sx_q ? (ZERO - rem_q) : rem_q;
      end
      OP_LOG2: begin
        // Zero input shifts all WIDTH positions, so lz_cnt==WIDTH means x==0.
        if (sx_q || lz_cnt == CW'(WIDTH)) err_d = 1'b1;
        else res_d = WIDTH'(WIDTH - 1) - WIDTH'(lz_cnt);
      end
      OP_RSVD: err_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_cnt <= '0;
      lz_cnt   <= '0;
      op_q     <= OP_DIV;
      sx_q     <= 1'b0;
      sy_q     <= 1'b0;
      x_min_q  <= 1'b0;
      dvs_q    <= ZERO;
      rem_q    <= ZERO;
      shreg_q  <= ZERO;
      out      <= ZERO;
      err      <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q     <= sel;
            sx_q     <= x[WIDTH-1];
            sy_q     <= y[WIDTH-1];
            x_min_q  <= (x == MIN_VAL);
            dvs_q    <= y_mag;
            rem_q    <= ZERO;
            shreg_q  <= (sel == OP_LOG2) ? x : x_mag;
            iter_cnt <= '0;
            lz_cnt   <= '0;
          end
        end
        ST_RUN: begin
          iter_cnt <= iter_cnt + CW'(1);
          if (op_q == OP_LOG2) begin
            if (!shreg_q[WIDTH-1]) begin
              shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
              lz_cnt  <= lz_cnt + CW'(1);
            end
          end else begin
            rem_q   <= step_rem;
            shreg_q <= {shreg_q[WIDTH-2:0], step_q};
          end
        end
        ST_FIX: begin
          out  <= res_d;
          err  <= err_d;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inverse_calculator.sv
module tb_inverse_calculator;
  import inverse_calc_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   sel;
  logic [W-1:0] x, y;
  logic         ready, done, err;
  logic [W-1:0] out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  inverse_calculator #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sel   (sel),
    .x     (x),
    .y     (y),
    .ready (ready),
    .done  (done),
    .out   (out),
    .err   (err)
  );

  typedef struct {
    logic [1:0] s;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] eo;
    logic       ee;
  } vec_t;

  vec_t tbl[19];

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Reference: plain integer arithmetic; returns {err, out}.
  function automatic logic [8:0] model(input logic [1:0] s, input logic [7:0] a,
                                       input logic [7:0] b);
    int ia, ib, q, k;
    ia = int'($signed(a));
    ib = int'($signed(b));
    case (s)
      2'd0: begin
        if (ib == 0) return {1'b1, 8'h00};
        if (ia == -128 && ib == -1) return {1'b1, 8'h80};
        q = ia / ib;
        return {1'b0, q[7:0]};
      end
      2'd1: begin
        if (ib == 0) return {1'b1, 8'h00};
        q = ia % ib;
        return {1'b0, q[7:0]};
      end
      2'd2: begin
        if (ia <= 0) return {1'b1, 8'h00};
        k = 0;
        while ((ia >> (k + 1)) != 0) k++;
        return {1'b0, 8'(k)};
      end
      default: return {1'b1, 8'h00};
    endcase
  endfunction

  // Issue one request, scramble operands after acceptance, wait for done.
  task automatic run_op(input logic [1:0] s, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] o, output logic e, output int lat);
    @(negedge clk);
    sel = s; x = a; y = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    x = 8'($urandom); y = 8'($urandom); sel = 2'($urandom);
    lat = 0; o = 8'h00; e = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) begin
        o = out; e = err;
        break;
      end
    end
  endtask

  initial begin
    logic [7:0] o;
    logic       e;
    int         lat, ndone, done_at;
    logic [8:0] ev;
    logic [1:0] rs;
    logic [7:0] ra, rb;
    int         r;
    bit         stable;

    tbl[0]  = '{OP_DIV,  8'd100, 8'd7,   8'h0E, 1'b0};
    tbl[1]  = '{OP_REM,  8'd100, 8'd7,   8'h02, 1'b0};
    tbl[2]  = '{OP_DIV,  8'h9C,  8'd7,   8'hF2, 1'b0};
    tbl[3]  = '{OP_REM,  8'h9C,  8'd7,   8'hFE, 1'b0};
    tbl[4]  = '{OP_REM,  8'd100, 8'hF9,  8'h02, 1'b0};
    tbl[5]  = '{OP_DIV,  8'h9C,  8'hF9,  8'h0E, 1'b0};
    tbl[6]  = '{OP_DIV,  8'h80,  8'hFF,  8'h80, 1'b1};
    tbl[7]  = '{OP_REM,  8'h80,  8'hFF,  8'h00, 1'b0};
    tbl[8]  = '{OP_DIV,  8'd5,   8'd0,   8'h00, 1'b1};
    tbl[9]  = '{OP_LOG2, 8'd100, 8'd0,   8'h06, 1'b0};
    tbl[10] = '{OP_LOG2, 8'd1,   8'd55,  8'h00, 1'b0};
    tbl[11] = '{OP_LOG2, 8'd127, 8'd0,   8'h06, 1'b0};
    tbl[12] = '{OP_LOG2, 8'hFD,  8'd0,   8'h00, 1'b1};
    tbl[13] = '{OP_RSVD, 8'd100, 8'd7,   8'h00, 1'b1};
    tbl[14] = '{OP_REM,  8'd5,   8'd0,   8'h00, 1'b1};
    tbl[15] = '{OP_LOG2, 8'd0,   8'd0,   8'h00, 1'b1};
    tbl[16] = '{OP_DIV,  8'h7F,  8'h80,  8'h00, 1'b0};
    tbl[17] = '{OP_DIV,  8'h80,  8'd2,   8'hC0, 1'b0};
    tbl[18] = '{OP_LOG2, 8'h80,  8'd0,   8'h00, 1'b1};

    rst_n = 1'b0; start = 1'b0; sel = 2'd0; x = '0; y = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", int'(ready), 1);
    check("reset_done",  int'(done),  0);
    check("reset_out",   int'(out),   0);
    check("reset_err",   int'(err),   0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      run_op(tbl[i].s, tbl[i].a, tbl[i].b, o, e, lat);
      check($sformatf("vec%0d_out", i), int'(o), int'(tbl[i].eo));
      check($sformatf("vec%0d_err", i), int'(e), int'(tbl[i].ee));
      check($sformatf("vec%0d_latency", i), lat, 9);
    end

    // done is a single-cycle pulse
    @(posedge clk); #1;
    check("done_pulse_width", int'(done), 0);

    for (int i = 0; i < 300; i++) begin
      rs = 2'($urandom_range(0, 3));
      ra = 8'($urandom);
      rb = 8'($urandom);
      r  = $urandom_range(0, 9);
      if (r == 0) rb = 8'h00;
      if (r == 1) rb = 8'hFF;
      if (r == 2) ra = 8'h80;
      ev = model(rs, ra, rb);
      run_op(rs, ra, rb, o, e, lat);
      check($sformatf("rnd%0d_out sel=%0d x=%0d y=%0d", i, rs, ra, rb), int'(o), int'(ev[7:0]));
      check($sformatf("rnd%0d_err", i), int'(e), int'(ev[8]));
      check($sformatf("rnd%0d_latency", i), lat, 9);
    end

    // start during RUN is ignored
    @(negedge clk);
    sel = OP_DIV; x = 8'd100; y = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; done_at = 0; o = 8'h00;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      start = (i == 3);
      sel = OP_REM; x = 8'd50; y = 8'd3;
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (done_at == 0) begin done_at = i; o = out; end
      end
    end
    start = 1'b0;
    check("ignore_start_ndone", ndone, 1);
    check("ignore_start_latency", done_at, 9);
    check("ignore_start_out", int'(o), 14);

    // back-to-back: new start in the done cycle, out held until next done
    @(negedge clk);
    sel = OP_LOG2; x = 8'd100; y = 8'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_at = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin done_at = i; break; end
    end
    check("b2b_first_latency", done_at, 9);
    check("b2b_ready_in_done", int'(ready), 1);
    check("b2b_first_out", int'(out), 6);
    sel = OP_DIV; x = 8'h9C; y = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; x = 8'd1; y = 8'd1;
    done_at = 0; stable = 1'b1; o = 8'h00;
    for (int i = 1; i <= 20; i++) begin
      if (!done && out != 8'd6) stable = 1'b0;
      @(posedge clk); #1;
      if (done) begin done_at = i; o = out; e = err; break; end
    end
    check("b2b_second_latency", done_at, 9);
    check("b2b_second_out", int'(o), int'(8'hF2));
    check("b2b_second_err", int'(e), 0);
    check("b2b_out_stable", int'(stable), 1);

    // reset mid-operation after a result with err=1
    run_op(OP_DIV, 8'h80, 8'hFF, o, e, lat);
    check("pre_reset_out", int'(o), int'(8'h80));
    check("pre_reset_err", int'(e), 1);
    @(negedge clk);
    sel = OP_DIV; x = 8'd100; y = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out",   int'(out),   0);
    check("abort_err",   int'(err),   0);
    check("abort_ready", int'(ready), 1);
    check("abort_done",  int'(done),  0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    run_op(OP_REM, 8'd100, 8'd7, o, e, lat);
    check("post_reset_out", int'(o), 2);
    check("post_reset_err", int'(e), 0);
    check("post_reset_latency", lat, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
